present_sbox_layer_iter: RTL and testbench
==========================================

# present_sbox_layer_iter

Iterative, parametrised PRESENT substitution layer. It applies the 4-bit PRESENT S-box, or its inverse, to every nibble of a WIDTH-bit state, processing LANES nibbles per clock. Valid/ready handshakes sit on both sides. It sits between the round-key XOR and the permutation layer in area-constrained encrypt/decrypt datapaths, where a full 16-S-box layer is too large.

## Interface
Parameters:
- WIDTH, 64, state width in bits; must be a multiple of 4*LANES.
- LANES, 4, S-box instances used per cycle; must divide WIDTH/4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt); sampled only on input accept.
- idat  input  WIDTH  state to substitute; sampled only on input accept.
- ivalid  input  1  input data valid.
- iready  output  1  block can accept; combinational from state, high only in IDLE.
- odat  output  WIDTH  substituted state; registered.
- ovalid  output  1  odat valid; registered.
- oready  input  1  downstream accepts odat.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Derived constant: NSTEP = WIDTH/(4*LANES).
- Step counter width: max(1, clog2(NSTEP)).
- States:
  - IDLE: iready=1. On ivalid&&iready, load idat into the state register, latch mode, clear the step counter, and go to BUSY.
  - BUSY: each cycle, replace nibbles [cnt*LANES .. cnt*LANES+LANES-1] (nibble 0 = bits 3:0) with their S-box or inverse-S-box image, using the latched mode. Increment cnt. On the step where cnt==NSTEP-1, go to DONE.
  - DONE: ovalid=1 and odat is held stable. On ovalid&&oready, go to IDLE.
- Forward S-box, inputs 0..F → outputs C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Inverse S-box, inputs 0..F → outputs 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Ignored inputs:
  - ivalid in BUSY or DONE is ignored; no queueing.
  - Changes to mode or idat after accept have no effect.
- Reset values: state IDLE, odat=0, ovalid=0, cnt=0, latched mode=0. iready=1 while rst_n is low and after release.
- Reset mid-operation: the partial result is discarded. The first edge after release may accept a new block.
- No wrap-around: cnt never exceeds NSTEP-1. With NSTEP=1, BUSY lasts exactly one cycle.
- odat is the working register itself. It is visible but not valid during BUSY, and the bench must check it only when ovalid=1.
- Illegal parameters: WIDTH%(4*LANES)!=0 or LANES==0 must stop elaboration with an error.

## Timing
- Latency: accept at edge k gives ovalid=1 after edge k+NSTEP.
  - Default parameters: NSTEP=4, latency 4 cycles.
- Output handshake completes at edge m. The earliest next accept is edge m+1 (IDLE for one cycle).
- Minimum period is NSTEP+2 cycles per block.
- Backpressure: ovalid stays high and odat is constant for any number of cycles with oready=0.
- No combinational path from ivalid/idat to any output.
- No combinational path from oready to iready.

## Structure
- Shared package present_pkg:
  - PRESENT_SBOX and PRESENT_INV_SBOX 16×4-bit constant arrays.
  - Functions present_sbox4(nibble) and present_inv_sbox4(nibble).
  - State enum localparams IDLE/BUSY/DONE.
- Sub-module present_sbox4_dual: purely combinational 4-bit in/out with a mode select. It is instantiated LANES times, and its inputs are muxed from the state register by cnt.

## Test plan
- Forward lookup, default params: mode=0, idat=0x0123456789ABCDEF. Required: odat=0xC56B90AD3EF84712, with ovalid rising exactly 4 cycles after accept.
- Inverse lookup: mode=1, idat=0xC56B90AD3EF84712 → 0x0123456789ABCDEF. Also mode=1, idat=0 → 0x5555555555555555.
- Parameter sweep:
  - LANES=16 with idat=0: latency 1, odat=0xCCCCCCCCCCCCCCCC.
  - LANES=1: latency 16, same result.
  - WIDTH=16, LANES=2, idat=0xFA50: odat=0x2F0C.
- Backpressure: hold oready=0 for 5 cycles after ovalid. Required: odat stable, and iready=0 throughout. A second ivalid pulse in that window is dropped, so only one output is produced.
- Reset mid-operation: pull rst_n low while cnt=2. Required:
  - Immediately: ovalid=0, odat=0, iready=1.
  - After release, the next block 0xFFFFFFFFFFFFFFFF with mode=0 yields 0x2222222222222222.
- Back-to-back with oready tied high: the second accept occurs exactly one cycle after the first output handshake, and mode is latched independently per block (mode=0 then mode=1).

Source files
------------

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// present_pkg : PRESENT S-box tables, lookup helpers and layer FSM states
// Rev 1.0
// ============================================================================
package present_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] PRESENT_INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [3:0] present_sbox4(input logic [3:0] nibble);
    return PRESENT_SBOX[nibble];
  endfunction

  function automatic logic [3:0] present_inv_sbox4(input logic [3:0] nibble);
    return PRESENT_INV_SBOX[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/present_sbox4_dual.sv
`default_nettype none
// ============================================================================
// present_sbox4_dual : combinational 4-bit PRESENT S-box, forward or inverse
// Rev 1.0
// ============================================================================
module present_sbox4_dual
  import present_pkg::*;
(
  input  logic       i_inv,
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = i_inv ? present_inv_sbox4(i_nib) : present_sbox4(i_nib);

endmodule
`default_nettype wire

// File: rtl/present_sbox_layer_iter.sv
`default_nettype none
// ============================================================================
// present_sbox_layer_iter : iterative PRESENT substitution layer, LANES nibbles
// per cycle, valid/ready on both sides.   Rev 1.0
// ============================================================================
module present_sbox_layer_iter
  import present_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] idat,
  input  logic             ivalid,
  output logic             iready,
  output logic [WIDTH-1:0] odat,
  output logic             ovalid,
  input  logic             oready
);

  // Guarded so an illegal LANES still elaborates far enough to hit the check.
  localparam int LDIV  = (LANES > 0) ? 4 * LANES : 4;
  localparam int NSTEP = ((WIDTH / LDIV) > 0) ? (WIDTH / LDIV) : 1;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int LBITS = LDIV;

  generate
    if ((LANES < 1) || ((WIDTH % LDIV) != 0)) begin : g_param_check
      $error("present_sbox_layer_iter: WIDTH must be a nonzero multiple of 4*LANES");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic [WIDTH-1:0] r_dat;
  logic [WIDTH-1:0] w_dat_nxt;
  logic             r_ovalid;
  logic             w_ovalid_nxt;

  logic [LBITS-1:0] w_lane_in;
  logic [LBITS-1:0] w_lane_out;
  logic [WIDTH-1:0] w_stepped;
  logic             w_last;

  assign w_last = (r_cnt == CW'(NSTEP - 1));

  // Select the group of LANES nibbles addressed by the step counter.
  always_comb begin
    w_lane_in = '0;
    for (int s = 0; s < NSTEP; s++) begin
      if (r_cnt == CW'(s)) begin
        w_lane_in = r_dat[s*LBITS +: LBITS];
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      present_sbox4_dual u_sbox (
        .i_inv (r_mode),
        .i_nib (w_lane_in[l*4 +: 4]),
        .o_nib (w_lane_out[l*4 +: 4])
      );
    end
  endgenerate

  // Write the substituted group back into the same slot of the working word.
  always_comb begin
    w_stepped = r_dat;
    for (int s = 0; s < NSTEP; s++) begin
      if (r_cnt == CW'(s)) begin
        w_stepped[s*LBITS +: LBITS] = w_lane_out;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mode_nxt   = r_mode;
    w_dat_nxt    = r_dat;
    w_ovalid_nxt = r_ovalid;
    case (r_state)
      IDLE: begin
        if (ivalid) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = '0;
          w_mode_nxt  = mode;
          w_dat_nxt   = idat;
        end
      end
      BUSY: begin
        w_dat_nxt = w_stepped;
        if (w_last) begin
          w_state_nxt  = DONE;
          w_ovalid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        if (oready) begin
          w_state_nxt  = IDLE;
          w_ovalid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_ovalid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_dat    <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode   <= w_mode_nxt;
      r_dat    <= w_dat_nxt;
      r_ovalid <= w_ovalid_nxt;
    end
  end

  assign iready = (r_state == IDLE);
  assign odat   = r_dat;
  assign ovalid = r_ovalid;

endmodule
`default_nettype wire

// File: tb/tb_present_sbox_layer_iter.sv
`default_nettype none
// ============================================================================
// tb_present_sbox_layer_iter : self-checking bench, nibble-table reference model
// Rev 1.0
// ============================================================================
module tb_present_sbox_layer_iter;

  localparam int NSTEP_DEF = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        mode   = 1'b0;
  logic [63:0] idat   = '0;
  logic        ivalid = 1'b0;
  logic        oready = 1'b0;
  logic        iready;
  logic        ovalid;
  logic [63:0] odat;

  logic        sw_ivalid = 1'b0;
  logic        sw_oready = 1'b1;
  logic        sw_mode   = 1'b0;
  logic [63:0] sw_idat   = '0;
  logic [15:0] sw_idat16 = 16'hFA50;
  logic        l16_iready, l16_ovalid, l1_iready, l1_ovalid, w16_iready, w16_ovalid;
  logic [63:0] l16_odat, l1_odat;
  logic [15:0] w16_odat;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_out    = 0;
  bit chk_on   = 1'b0;

  int fwd_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  int inv_tab [16] = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};

  bit          m_idle   = 1'b1;
  bit          m_ovalid = 1'b0;
  int          m_wait   = 0;
  logic [63:0] m_pend   = '0;
  logic [63:0] m_res    = '0;

  always #5 clk = ~clk;

  present_sbox_layer_iter #(.WIDTH(64), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .idat(idat), .ivalid(ivalid),
    .iready(iready), .odat(odat), .ovalid(ovalid), .oready(oready)
  );

  present_sbox_layer_iter #(.WIDTH(64), .LANES(16)) dut_l16 (
    .clk(clk), .rst_n(rst_n), .mode(sw_mode), .idat(sw_idat), .ivalid(sw_ivalid),
    .iready(l16_iready), .odat(l16_odat), .ovalid(l16_ovalid), .oready(sw_oready)
  );

  present_sbox_layer_iter #(.WIDTH(64), .LANES(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .mode(sw_mode), .idat(sw_idat), .ivalid(sw_ivalid),
    .iready(l1_iready), .odat(l1_odat), .ovalid(l1_ovalid), .oready(sw_oready)
  );

  present_sbox_layer_iter #(.WIDTH(16), .LANES(2)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .mode(sw_mode), .idat(sw_idat16), .ivalid(sw_ivalid),
    .iready(w16_iready), .odat(w16_odat), .ovalid(w16_ovalid), .oready(sw_oready)
  );

  function automatic logic [63:0] sub_layer(input logic [63:0] x, input logic inv, input int nibs);
    logic [63:0] r;
    logic [3:0]  n;
    r = x;
    for (int i = 0; i < nibs; i++) begin
      n = x[i*4 +: 4];
      r[i*4 +: 4] = inv ? 4'(inv_tab[n]) : 4'(fwd_tab[n]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired cycle=%0d", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: accept when idle, result appears NSTEP edges later, held until taken.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_idle   = 1'b1;
      m_ovalid = 1'b0;
      m_wait   = 0;
    end else if (m_idle) begin
      if (ivalid) begin
        m_idle = 1'b0;
        m_pend = sub_layer(idat, mode, 16);
        m_wait = NSTEP_DEF;
      end
    end else if (!m_ovalid) begin
      m_wait--;
      if (m_wait == 0) begin
        m_ovalid = 1'b1;
        m_res    = m_pend;
      end
    end else if (oready) begin
      m_ovalid = 1'b0;
      m_idle   = 1'b1;
    end
  end

  initial begin
    bit prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (ovalid && !prev_ov) n_out++;
      prev_ov = ovalid;
      if (chk_on) begin
        chk("iready", 64'(iready), 64'(m_idle));
        chk("ovalid", 64'(ovalid), 64'(m_ovalid));
        if (m_ovalid) chk("odat", odat, m_res);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic m, output int acc);
    int tries;
    tries = 0;
    @(posedge clk); #1;
    while (!m_idle && tries < 100) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!m_idle) fail_now("send_wait_idle");
    ivalid = 1'b1;
    idat   = d;
    mode   = m;
    @(posedge clk); #1;
    acc    = cyc;
    ivalid = 1'b0;
    idat   = {$urandom, $urandom};
    mode   = ~m;
  endtask

  task automatic wait_ovalid(input int maxc, output int seen);
    seen = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ovalid) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) fail_now("wait_ovalid");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k, t1, t2, h0, lat16, lat1, latw;
    logic [63:0] held, r, o16, o1;
    logic [15:0] ow;

    #1;
    rst_n  = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_iready", 64'(iready), 64'd1);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_odat", odat, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    chk("model_fwd", sub_layer(64'h0123456789ABCDEF, 1'b0, 16), 64'hC56B90AD3EF84712);
    chk("model_inv", sub_layer(64'hC56B90AD3EF84712, 1'b1, 16), 64'h0123456789ABCDEF);
    chk("model_inv0", sub_layer(64'h0, 1'b1, 16), 64'h5555555555555555);
    chk("model_w16", sub_layer(64'hFA50, 1'b0, 4), 64'h2F0C);

    oready = 1'b1;
    send(64'h0123456789ABCDEF, 1'b0, k);
    wait_ovalid(40, t1);
    chk("fwd_latency", 64'(t1 - k), 64'd4);
    chk("fwd_odat", odat, 64'hC56B90AD3EF84712);

    send(64'hC56B90AD3EF84712, 1'b1, k);
    wait_ovalid(40, t1);
    chk("inv_latency", 64'(t1 - k), 64'd4);
    chk("inv_odat", odat, 64'h0123456789ABCDEF);

    send(64'h0, 1'b1, k);
    wait_ovalid(40, t1);
    chk("inv0_odat", odat, 64'h5555555555555555);

    // Parameter sweep: one pulse to all three alternate instances.
    @(posedge clk); #1;
    sw_ivalid = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sw_ivalid = 1'b0;
    lat16 = -1; lat1 = -1; latw = -1;
    o16 = '0; o1 = '0; ow = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (l16_ovalid && lat16 < 0) begin lat16 = cyc - k; o16 = l16_odat; end
      if (l1_ovalid && lat1 < 0) begin lat1 = cyc - k; o1 = l1_odat; end
      if (w16_ovalid && latw < 0) begin latw = cyc - k; ow = w16_odat; end
    end
    chk("l16_latency", 64'(lat16), 64'd1);
    chk("l16_odat", o16, 64'hCCCCCCCCCCCCCCCC);
    chk("l1_latency", 64'(lat1), 64'd16);
    chk("l1_odat", o1, 64'hCCCCCCCCCCCCCCCC);
    chk("w16_latency", 64'(latw), 64'd2);
    chk("w16_odat", 64'(ow), 64'h2F0C);

    // Backpressure with a dropped second request.
    oready = 1'b0;
    r = {$urandom, $urandom};
    h0 = n_out;
    send(r, 1'b0, k);
    wait_ovalid(40, t1);
    held = odat;
    chk("bp_odat", odat, sub_layer(r, 1'b0, 16));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin ivalid = 1'b1; idat = ~r; mode = 1'b1; end
      if (i == 3) ivalid = 1'b0;
      @(negedge clk);
      chk("bp_hold", odat, held);
      chk("bp_iready", 64'(iready), 64'd0);
      chk("bp_ovalid", 64'(ovalid), 64'd1);
    end
    oready = 1'b1;
    repeat (15) @(negedge clk);
    chk("bp_one_output", 64'(n_out - h0), 64'd1);

    // Reset while cnt==2.
    send({$urandom, $urandom}, 1'b0, k);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ovalid", 64'(ovalid), 64'd0);
    chk("midrst_odat", odat, 64'd0);
    chk("midrst_iready", 64'(iready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'hFFFFFFFFFFFFFFFF, 1'b0, k);
    wait_ovalid(40, t1);
    chk("postrst_latency", 64'(t1 - k), 64'd4);
    chk("postrst_odat", odat, 64'h2222222222222222);

    // Back-to-back: ivalid held high, second block latched with its own mode.
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    ivalid = 1'b1;
    idat   = 64'h0123456789ABCDEF;
    mode   = 1'b0;
    @(posedge clk); #1;
    k    = cyc;
    idat = 64'hC56B90AD3EF84712;
    mode = 1'b1;
    wait_ovalid(40, t1);
    chk("b2b_lat1", 64'(t1 - k), 64'd4);
    chk("b2b_odat1", odat, 64'hC56B90AD3EF84712);
    @(negedge clk);
    wait_ovalid(40, t2);
    ivalid = 1'b0;
    chk("b2b_spacing", 64'(t2 - t1), 64'(NSTEP_DEF + 2));
    chk("b2b_odat2", odat, 64'h0123456789ABCDEF);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      ivalid = ($urandom_range(0, 2) == 0);
      idat   = {$urandom, $urandom};
      mode   = 1'($urandom_range(0, 1));
      oready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    ivalid = 1'b0;
    oready = 1'b1;
    repeat (20) @(negedge clk);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
